// File: rtl/sample_hold_pkg.sv
// sample_hold_pkg
//   Shared types and defaults for the sample/hold bank.
//   - hold_mode_e : what a disabled channel does (keep last value or clear to 0)
//   - cnt_w()     : bit width needed to count 0..STALE_MAX inclusive
//   - DEF_*       : default parameter values used by the bank and channel
// Optional feature macro: SAMPLE_HOLD_STALE_EN (staleness counters).
package sample_hold_pkg;

  typedef enum logic {
    HOLD_LAST = 1'b0,
    HOLD_ZERO = 1'b1
  } hold_mode_e;

  localparam int         DEF_CH        = 4;
  localparam int         DEF_DW        = 8;
  localparam int         DEF_EW        = 8;
  localparam hold_mode_e DEF_MODE      = HOLD_LAST;
  localparam int         DEF_STALE_MAX = 15;

  // Smallest width w with 2**w > max_val, i.e. $clog2(max_val+1), minimum 1.
  function automatic int cnt_w(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/sample_hold_chan.sv
// sample_hold_chan
//   One channel of the sample/hold bank: data register, change strobe and
//   (with SAMPLE_HOLD_STALE_EN defined) a saturating staleness counter.
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   d   [DW-1:0]     data to load
//   en  [EW-1:0]     enable vector; channel loads when any bit is set
//   freeze           blocks loads, clears and counting
//   clr              synchronous clear (beats freeze)
//   q   [DW-1:0]     held value
//   upd              one-cycle pulse when q changed on the last edge
//   stale            counter has reached STALE_MAX (0 when feature is off)
module sample_hold_chan
  import sample_hold_pkg::*;
#(
  parameter int         DW        = DEF_DW,
  parameter int         EW        = DEF_EW,
  parameter hold_mode_e MODE      = DEF_MODE,
  parameter int         STALE_MAX = DEF_STALE_MAX
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] d,
  input  logic [EW-1:0] en,
  input  logic          freeze,
  input  logic          clr,
  output logic [DW-1:0] q,
  output logic          upd,
  output logic          stale
);

  logic          en_c;
  logic [DW-1:0] data_reg, data_next;
  logic          upd_reg, upd_next;

  assign en_c = |en;

  always_comb begin
    data_next = data_reg;
    upd_next  = 1'b0;
    if (clr) begin
      data_next = '0;
      upd_next  = (data_reg != '0);
    end else if (freeze) begin
      data_next = data_reg;
    end else if (en_c) begin
      // Rewriting an identical value is not a change, so no strobe.
      data_next = d;
      upd_next  = (d != data_reg);
    end else if (MODE == HOLD_ZERO) begin
      data_next = '0;
      upd_next  = (data_reg != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg <= '0;
      upd_reg  <= 1'b0;
    end else begin
      data_reg <= data_next;
      upd_reg  <= upd_next;
    end
  end

  assign q   = data_reg;
  assign upd = upd_reg;

`ifdef SAMPLE_HOLD_STALE_EN
  localparam int            CW      = cnt_w(STALE_MAX);
  localparam logic [CW-1:0] CNT_MAX = CW'(STALE_MAX);

  logic [CW-1:0] cnt_reg, cnt_next;
  logic          stale_reg;

  // Counts idle (enabled-off) cycles; saturates rather than wrapping so a
  // channel idle for a long time stays stale.
  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (freeze) begin
      cnt_next = cnt_reg;
    end else if (en_c) begin
      cnt_next = '0;
    end else if (cnt_reg != CNT_MAX) begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  // stale is decoded from the next counter value so it is a flop output yet
  // lines up with the counter register itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      stale_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      stale_reg <= (cnt_next == CNT_MAX);
    end
  end

  assign stale = stale_reg;
`else
  assign stale = 1'b0;
`endif

endmodule

// File: rtl/sample_hold_bank.sv
// sample_hold_bank
//   Multi-channel registered conditional-hold bank. Each channel loads its
//   data when its enable vector is non-zero; otherwise it holds (HOLD_LAST)
//   or clears (HOLD_ZERO). clr beats freeze, freeze beats loading.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_data  [CH*DW-1:0]  channel c at [c*DW +: DW]
//   in_en    [CH*EW-1:0]  channel c enable vector at [c*EW +: EW]
//   freeze                global load/clear/count block
//   clr                   global synchronous clear
//   out_data [CH*DW-1:0]  held values
//   out_upd  [CH-1:0]     per-channel change strobes
//   stale    [CH-1:0]     per-channel staleness flags
// Optional feature macro: SAMPLE_HOLD_STALE_EN (otherwise stale is 0).
module sample_hold_bank
  import sample_hold_pkg::*;
#(
  parameter int         CH        = DEF_CH,
  parameter int         DW        = DEF_DW,
  parameter int         EW        = DEF_EW,
  parameter hold_mode_e MODE      = DEF_MODE,
  parameter int         STALE_MAX = DEF_STALE_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH*DW-1:0] in_data,
  input  logic [CH*EW-1:0] in_en,
  input  logic             freeze,
  input  logic             clr,
  output logic [CH*DW-1:0] out_data,
  output logic [CH-1:0]    out_upd,
  output logic [CH-1:0]    stale
);

  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_chan
      sample_hold_chan #(
        .DW       (DW),
        .EW       (EW),
        .MODE     (MODE),
        .STALE_MAX(STALE_MAX)
      ) u_chan (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (in_data[gi*DW +: DW]),
        .en    (in_en[gi*EW +: EW]),
        .freeze(freeze),
        .clr   (clr),
        .q     (out_data[gi*DW +: DW]),
        .upd   (out_upd[gi]),
        .stale (stale[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sample_hold_bank.sv
// tb_sample_hold_bank
//   Drives a HOLD_LAST and a HOLD_ZERO bank from the same inputs and compares
//   both against a behavioural model, a directed vector table, hand-written
//   corner sequences and random traffic.
module tb_sample_hold_bank;
  import sample_hold_pkg::*;

  localparam int CH   = 4;
  localparam int DW   = 8;
  localparam int EW   = 8;
  localparam int SMAX = 3;

  logic             clk;
  logic             rst_n;
  logic [CH*DW-1:0] in_data;
  logic [CH*EW-1:0] in_en;
  logic             freeze;
  logic             clr;
  logic [CH*DW-1:0] out_data_l, out_data_z;
  logic [CH-1:0]    out_upd_l, out_upd_z;
  logic [CH-1:0]    stale_l, stale_z;

  sample_hold_bank #(.CH(CH), .DW(DW), .EW(EW), .MODE(HOLD_LAST), .STALE_MAX(SMAX)) dut_last (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_en(in_en), .freeze(freeze), .clr(clr),
    .out_data(out_data_l), .out_upd(out_upd_l), .stale(stale_l)
  );

  sample_hold_bank #(.CH(CH), .DW(DW), .EW(EW), .MODE(HOLD_ZERO), .STALE_MAX(SMAX)) dut_zero (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_en(in_en), .freeze(freeze), .clr(clr),
    .out_data(out_data_z), .out_upd(out_upd_z), .stale(stale_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: index 0 = HOLD_LAST bank, 1 = HOLD_ZERO bank.
  logic [DW-1:0] m_val [2][CH];
  logic          m_upd [2][CH];
  int            m_cnt [CH];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < CH; c++) begin
        m_val[m][c] = '0;
        m_upd[m][c] = 1'b0;
      end
    for (int c = 0; c < CH; c++) m_cnt[c] = 0;
  endtask

  // One clock of the rules, applied to the inputs currently on the pins.
  task automatic model_step();
    logic [DW-1:0] dv;
    logic          en;
    for (int c = 0; c < CH; c++) begin
      dv = in_data[c*DW +: DW];
      en = (in_en[c*EW +: EW] != 0);
      for (int m = 0; m < 2; m++) begin
        if (clr) begin
          m_upd[m][c] = (m_val[m][c] != 0);
          m_val[m][c] = 0;
        end else if (freeze) begin
          m_upd[m][c] = 1'b0;
        end else if (en) begin
          m_upd[m][c] = (dv != m_val[m][c]);
          m_val[m][c] = dv;
        end else if (m == 1) begin
          m_upd[m][c] = (m_val[m][c] != 0);
          m_val[m][c] = 0;
        end else begin
          m_upd[m][c] = 1'b0;
        end
      end
      if (clr || (!freeze && en)) m_cnt[c] = 0;
      else if (!freeze && m_cnt[c] < SMAX) m_cnt[c] = m_cnt[c] + 1;
    end
  endtask

  function automatic logic [CH-1:0] exp_stale();
    logic [CH-1:0] s;
    s = '0;
`ifdef SAMPLE_HOLD_STALE_EN
    for (int c = 0; c < CH; c++) s[c] = (m_cnt[c] == SMAX);
`endif
    return s;
  endfunction

  task automatic check_model(input string tag);
    logic [CH*DW-1:0] ed_l, ed_z;
    logic [CH-1:0]    eu_l, eu_z;
    for (int c = 0; c < CH; c++) begin
      ed_l[c*DW +: DW] = m_val[0][c];
      ed_z[c*DW +: DW] = m_val[1][c];
      eu_l[c] = m_upd[0][c];
      eu_z[c] = m_upd[1][c];
    end
    chk({tag, " last.data"},  64'(out_data_l), 64'(ed_l));
    chk({tag, " last.upd"},   64'(out_upd_l),  64'(eu_l));
    chk({tag, " last.stale"}, 64'(stale_l),    64'(exp_stale()));
    chk({tag, " zero.data"},  64'(out_data_z), 64'(ed_z));
    chk({tag, " zero.upd"},   64'(out_upd_z),  64'(eu_z));
    chk({tag, " zero.stale"}, 64'(stale_z),    64'(exp_stale()));
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    logic [EW-1:0] en;
    logic [DW-1:0] d;
    logic          fz;
    logic          cl;
    logic [DW-1:0] exp_l;
    logic          upd_l;
    logic [DW-1:0] exp_z;
    logic          upd_z;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // Channel 0 walk; other channels stay disabled at 0.
    vecs[0] = '{8'h01, 8'h01, 0, 0, 8'h01, 1, 8'h01, 1};
    vecs[1] = '{8'h00, 8'h03, 0, 0, 8'h01, 0, 8'h00, 1};
    vecs[2] = '{8'h02, 8'h05, 0, 0, 8'h05, 1, 8'h05, 1};
    vecs[3] = '{8'h00, 8'h07, 0, 0, 8'h05, 0, 8'h00, 1};
    vecs[4] = '{8'h80, 8'h05, 0, 0, 8'h05, 0, 8'h05, 1};
    vecs[5] = '{8'hFF, 8'hAA, 0, 0, 8'hAA, 1, 8'hAA, 1};
    vecs[6] = '{8'hFF, 8'h55, 1, 0, 8'hAA, 0, 8'hAA, 0};
    vecs[7] = '{8'hFF, 8'h55, 1, 1, 8'h00, 1, 8'h00, 1};
    vecs[8] = '{8'h00, 8'h00, 0, 1, 8'h00, 0, 8'h00, 0};
    vecs[9] = '{8'h00, 8'h09, 0, 0, 8'h00, 0, 8'h00, 0};

    rst_n = 1'b0; in_data = '0; in_en = '0; freeze = 1'b0; clr = 1'b0;
    model_reset();
    #2;
    check_model("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      in_en   = {{(CH-1)*EW{1'b0}}, vecs[i].en};
      in_data = {{(CH-1)*DW{1'b0}}, vecs[i].d};
      freeze  = vecs[i].fz;
      clr     = vecs[i].cl;
      cycle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl last.d0", i), 64'(out_data_l[DW-1:0]), 64'(vecs[i].exp_l));
      chk($sformatf("vec%0d tbl last.u0", i), 64'(out_upd_l[0]),       64'(vecs[i].upd_l));
      chk($sformatf("vec%0d tbl zero.d0", i), 64'(out_data_z[DW-1:0]), 64'(vecs[i].exp_z));
      chk($sformatf("vec%0d tbl zero.u0", i), 64'(out_upd_z[0]),       64'(vecs[i].upd_z));
    end
    freeze = 1'b0; clr = 1'b0;

    // Multi-channel independence
    in_en = {8'h01, 8'h01, 8'h01, 8'h01}; in_data = {8'h04, 8'h03, 8'h02, 8'h01};
    cycle("mc preload");
    in_en = {8'h01, 8'h00, 8'h01, 8'h00}; in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    cycle("mc load");
    chk("mc last.data", 64'(out_data_l), 64'({8'h44, 8'h03, 8'h22, 8'h01}));
    chk("mc last.upd",  64'(out_upd_l),  64'(4'b1010));

    // Staleness: all idle 3 cycles, 10 more, then reload
    in_en = '0;
    for (int i = 0; i < 3; i++) cycle($sformatf("stale hold%0d", i));
`ifdef SAMPLE_HOLD_STALE_EN
    chk("stale after 3", 64'(stale_l), 64'(4'hF));
`else
    chk("stale off", 64'(stale_l), 64'(4'h0));
`endif
    for (int i = 0; i < 10; i++) cycle($sformatf("stale sat%0d", i));
    in_en = {8'h00, 8'h00, 8'h00, 8'h10}; in_data = {CH{8'h66}};
    cycle("stale reload");
    chk("stale reload ch0", 64'(stale_l[0]), 64'(1'b0));

    // Freeze keeps counters frozen
    in_en = '0; freeze = 1'b1;
    cycle("frozen idle");
    freeze = 1'b0;

    // Async reset mid-operation
    in_en = {24'h0, 8'h01}; in_data = {24'h0, 8'h5A};
    cycle("rst preload");
    in_en = '0;
    cycle("rst hold1");
    cycle("rst hold2");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_model("async reset");
    rst_n = 1'b1;
    in_en = {24'h0, 8'h01}; in_data = {24'h0, 8'h5A};
    cycle("post reset load");
    chk("post reset d0", 64'(out_data_l[DW-1:0]), 64'(8'h5A));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < CH; c++) begin
        in_en[c*EW +: EW]   = ($urandom_range(0, 1) == 0) ? '0 : EW'(1 << $urandom_range(0, EW-1));
        in_data[c*DW +: DW] = ($urandom_range(0, 3) == 0) ? in_data[c*DW +: DW] : DW'($urandom);
      end
      freeze = ($urandom_range(0, 9) == 0);
      clr    = ($urandom_range(0, 19) == 0);
      cycle($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
